seg_display_scheduler: RTL and testbench
========================================

Name: seg_display_scheduler

Overview:
- Owns the 3-digit multiplexed 7-segment display and shares it between two requesters.
  - Source 0: voltage readout, background priority.
  - Source 1: status/alert message, high priority, minimum hold time.
- Arbitrates only on a periodic update tick and latches the winner's nibbles into shadow registers.
- Scans the digits and drives active-low enables, segments and decimal point.
- Sits between the voltage calculator / status logic and the board display pins.

Parameters:
- SCAN_DIV, 48000: clk cycles per digit slot (4 ms at 12 MHz).
- UPDATE_DIV, 6000000: clk cycles per update tick (0.5 s at 12 MHz).
- HOLD_UPDATES, 4: minimum number of update ticks that source 1 keeps the display once granted (≥1).

Ports:
- clk  in  1  12 MHz system clock
- rst  in  1  synchronous reset, active high
- req0  in  1  source 0 wants display
- src0_d0 / src0_d1 / src0_d2  in  4 each  source 0 digit values (d0 leftmost)
- src0_dp  in  3  source 0 decimal-point mask, bit i lights DP on digit i
- req1  in  1  source 1 wants display
- src1_d0 / src1_d1 / src1_d2  in  4 each  source 1 digit values
- src1_dp  in  3  source 1 DP mask
- ack0  out  1  one-cycle pulse: source 0 data latched
- ack1  out  1  one-cycle pulse: source 1 data latched
- grant  out  2  current owner: 00 none, 01 src0, 10 src1
- en  out  4  digit enables, active low; en[3] always 1
- svn_conf  out  7  segments, active low
- DP  out  1  decimal point, active low

Behaviour:
- Reset (rst=1 at posedge, regardless of state):
  - State BLANK, all counters 0, digit index 0, shadow regs 0, hold counter 0.
  - Outputs: en=1111, svn_conf=1111111, DP=1, ack0=ack1=0, grant=00.
- Scan counter:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index advances 0→1→2→0. Index 3 is never reached.
- Update counter:
  - Counts 0..UPDATE_DIV-1.
  - The edge at which it equals UPDATE_DIV-1 is the tick: counter wraps to 0 and the FSM evaluates.
  - Requests are sampled only at the tick; req changes between ticks have no effect.
- FSM transitions at the tick:
  - BLANK: req1 → HOLD1; else req0 → SHOW0; else stay BLANK.
  - SHOW0: req1 → HOLD1; else req0 → SHOW0; else BLANK.
  - HOLD1: entry loads hold_cnt=HOLD_UPDATES-1.
    - Each later tick decrements hold_cnt.
    - If hold_cnt==0 at the tick, go to SHOW1 and re-evaluate within the same tick using the SHOW1 rules.
    - HOLD_UPDATES=1 therefore behaves as a plain SHOW1.
  - SHOW1: req1 → SHOW1; else req0 → SHOW0; else BLANK.
- Latching at the tick:
  - Shadow regs latch the next state's source when that source's req is 1; the matching ack pulses high for exactly the cycle after the edge.
  - In HOLD1 with req1=0, shadow is frozen and no ack is issued.
  - Simultaneous req0/req1 at a tick: source 1 wins and ack0 stays 0.
- grant is registered and updates on the tick edge.
- Display outputs:
  - en/svn_conf/DP are registered from the current digit index and shadow, so they lag the digit index by 1 cycle.
  - en per index: 0→1110, 1→1101, 2→1011.
  - DP = ~shadow_dp[index].
  - svn_conf = hex decode of the shadow nibble: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
  - In BLANK: en=1111, svn_conf=1111111, DP=1.
- New data becomes visible at most one digit slot plus 1 cycle after the tick. Scan phase is not reset by the tick.

Optional Feature:
- Macro: SEG_DIM_EN.
- Defined:
  - Adds input `dim` (1 bit).
  - When dim=1, the active en bit is driven low only while scan_cnt < SCAN_DIV/4, and en=1111 otherwise (25 % duty). svn_conf/DP are unaffected.
  - dim=0 gives full duty.
- Undefined: no `dim` port; full duty always.

Decomposition:
- Package seg_disp_pkg holds:
  - the FSM state enum (BLANK, SHOW0, HOLD1, SHOW1);
  - grant encodings;
  - the digit enable patterns;
  - SEG_BLANK=7'b1111111;
  - NUM_DIGITS=3.
- One sub-module: seg_hex_decoder, a combinational nibble→active-low segment map, instantiated once.
- Scan counter, update counter and FSM stay in the top module.

Test Plan:
All scenarios use SCAN_DIV=4, UPDATE_DIV=16, HOLD_UPDATES=2.
1. Reset, no requests for 64 cycles → en=1111, svn_conf=1111111, DP=1, grant=00; acks never pulse.
2. req0=1, src0=3,1,4, dp=001, held from reset release → ack0 pulses once per 16 cycles; grant=01; en scans 1110/1101/1011 at 4 cycles each; svn_conf 0110000/1111001/0011001; DP=0 only on 1110.
3. req0=1, then req1 pulsed for 3 cycles mid-period with src1=E,0,1 covering a tick → at that tick ack1=1, ack0=0, grant=10. Source-1 digits persist one more tick with no ack. Next tick returns to grant=01 with ack0.
4. req0=req1=1 both held → ack1 every tick, ack0 never, grant stays 10.
5. rst asserted for 1 cycle while grant=10 in HOLD1 → next cycle all reset values. After release, the first tick occurs 16 cycles later.
6. SEG_DIM_EN with dim=1, req0=1 → each en low pattern lasts exactly 1 of every 4 cycles. With dim=0 → 4 of 4.

Source files
------------

// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the multiplexed 3-digit 7-segment display scheduler.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    SHOW0 = 2'd1,
    HOLD1 = 2'd2,
    SHOW1 = 2'd3
  } disp_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_SRC0 = 2'b01;
  localparam logic [1:0] GRANT_SRC1 = 2'b10;

  localparam int unsigned NUM_DIGITS = 3;

  localparam logic [3:0] EN_OFF  = 4'b1111;
  localparam logic [3:0] EN_DIG0 = 4'b1110;
  localparam logic [3:0] EN_DIG1 = 4'b1101;
  localparam logic [3:0] EN_DIG2 = 4'b1011;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [3:0] digit_enable(input logic [1:0] idx);
    case (idx)
      2'd0:    digit_enable = EN_DIG0;
      2'd1:    digit_enable = EN_DIG1;
      2'd2:    digit_enable = EN_DIG2;
      default: digit_enable = EN_OFF;
    endcase
  endfunction

  function automatic logic [1:0] grant_of(input disp_state_t s);
    case (s)
      SHOW0:        grant_of = GRANT_SRC0;
      HOLD1, SHOW1: grant_of = GRANT_SRC1;
      default:      grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low 7-segment pattern (gfedcba order).
module seg_hex_decoder
  import seg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Arbitrates the 3-digit display between a background and a high-priority source and scans it.
// Optional SEG_DIM_EN adds a 'dim' input giving 25 % digit-enable duty.
module seg_display_scheduler
  import seg_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 48000,
  parameter int unsigned UPDATE_DIV   = 6000000,
  parameter int unsigned HOLD_UPDATES = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SEG_DIM_EN
  input  logic       dim,
`endif
  input  logic       req0,
  input  logic [3:0] src0_d0,
  input  logic [3:0] src0_d1,
  input  logic [3:0] src0_d2,
  input  logic [2:0] src0_dp,
  input  logic       req1,
  input  logic [3:0] src1_d0,
  input  logic [3:0] src1_d1,
  input  logic [3:0] src1_d2,
  input  logic [2:0] src1_dp,
  output logic       ack0,
  output logic       ack1,
  output logic [1:0] grant,
  output logic [3:0] en,
  output logic [6:0] svn_conf,
  output logic       DP
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned UPD_W  = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_UPDATES > 1) ? $clog2(HOLD_UPDATES) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [UPD_W-1:0]  UPD_LAST  = UPD_W'(UPDATE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_UPDATES - 1);
  localparam logic [1:0]        IDX_LAST  = 2'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0] scan_cnt;
  logic [UPD_W-1:0]  upd_cnt;
  logic [1:0]        digit_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] nxt_hold;
  disp_state_t       state;
  disp_state_t       nxt_state;
  logic              tick;
  logic              load0;
  logic              load1;
  logic              dim_off;

  logic [NUM_DIGITS-1:0][3:0] shadow_d;
  logic [NUM_DIGITS-1:0]      shadow_dp;
  logic [6:0]                 seg_dec;

  assign tick = (upd_cnt == UPD_LAST);

`ifdef SEG_DIM_EN
  assign dim_off = dim && (scan_cnt >= SCAN_W'(SCAN_DIV / 4));
`else
  assign dim_off = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       upd_cnt <= '0;
    else if (tick) upd_cnt <= '0;
    else           upd_cnt <= upd_cnt + 1'b1;
  end

  // An expired hold falls straight through to the SHOW1 rules in the same tick.
  always_comb begin
    nxt_state = state;
    nxt_hold  = hold_cnt;
    load0     = 1'b0;
    load1     = 1'b0;
    if (tick) begin
      case (state)
        BLANK, SHOW0: begin
          if (req1) begin
            nxt_state = HOLD1;
            nxt_hold  = HOLD_INIT;
            load1     = 1'b1;
          end else if (req0) begin
            nxt_state = SHOW0;
            load0     = 1'b1;
          end else begin
            nxt_state = BLANK;
          end
        end
        default: begin
          if (state == HOLD1 && hold_cnt != '0) begin
            nxt_hold = hold_cnt - 1'b1;
            load1    = req1;
          end else if (req1) begin
            nxt_state = SHOW1;
            load1     = 1'b1;
          end else if (req0) begin
            nxt_state = SHOW0;
            load0     = 1'b1;
          end else begin
            nxt_state = BLANK;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BLANK;
      hold_cnt  <= '0;
      grant     <= GRANT_NONE;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      shadow_d  <= '0;
      shadow_dp <= '0;
    end else begin
      state    <= nxt_state;
      hold_cnt <= nxt_hold;
      ack0     <= load0;
      ack1     <= load1;
      if (tick) grant <= grant_of(nxt_state);
      if (load1) begin
        shadow_d  <= {src1_d2, src1_d1, src1_d0};
        shadow_dp <= src1_dp;
      end else if (load0) begin
        shadow_d  <= {src0_d2, src0_d1, src0_d0};
        shadow_dp <= src0_dp;
      end
    end
  end

  seg_hex_decoder u_dec (
    .nibble (shadow_d[digit_idx]),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (rst || state == BLANK) begin
      en       <= EN_OFF;
      svn_conf <= SEG_BLANK;
      DP       <= 1'b1;
    end else begin
      en       <= dim_off ? EN_OFF : digit_enable(digit_idx);
      svn_conf <= seg_dec;
      DP       <= ~shadow_dp[digit_idx];
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed self-checking bench for seg_display_scheduler (SCAN_DIV=4, UPDATE_DIV=16, HOLD_UPDATES=2).
module tb_seg_display_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] src0_d0 = '0, src0_d1 = '0, src0_d2 = '0;
  logic [3:0] src1_d0 = '0, src1_d1 = '0, src1_d2 = '0;
  logic [2:0] src0_dp = '0, src1_dp = '0;
`ifdef SEG_DIM_EN
  logic       dim = 1'b0;
`endif
  logic       ack0, ack1, DP;
  logic [1:0] grant;
  logic [3:0] en;
  logic [6:0] svn_conf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  seg_display_scheduler #(.SCAN_DIV(4), .UPDATE_DIV(16), .HOLD_UPDATES(2)) dut (
    .clk(clk), .rst(rst),
`ifdef SEG_DIM_EN
    .dim(dim),
`endif
    .req0(req0), .src0_d0(src0_d0), .src0_d1(src0_d1), .src0_d2(src0_d2), .src0_dp(src0_dp),
    .req1(req1), .src1_d0(src1_d0), .src1_d1(src1_d1), .src1_d2(src1_d2), .src1_dp(src1_dp),
    .ack0(ack0), .ack1(ack1), .grant(grant), .en(en), .svn_conf(svn_conf), .DP(DP)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_en(input int i);
    case (i)
      0:       exp_en = 4'b1110;
      1:       exp_en = 4'b1101;
      default: exp_en = 4'b1011;
    endcase
  endfunction

  // Segment patterns for source 0 digits 3,1,4.
  function automatic logic [6:0] exp_seg0(input int i);
    case (i)
      0:       exp_seg0 = 7'b0110000;
      1:       exp_seg0 = 7'b1111001;
      default: exp_seg0 = 7'b0011001;
    endcase
  endfunction

  task automatic chk_blank(input string tag);
    chk({tag, "_en"},  7'(en), 7'b0001111);
    chk({tag, "_seg"}, svn_conf, 7'b1111111);
    chk({tag, "_dp"},  7'(DP), 7'd1);
  endtask

  initial begin
    int i;

    // 1: idle after reset
    do_reset();
    chk_blank("rst_idle");
    chk("rst_grant", 7'(grant), 7'd0);
    for (int k = 0; k < 64; k++) begin
      step();
      chk_blank("idle");
      chk("idle_grant", 7'(grant), 7'd0);
      chk("idle_ack0", 7'(ack0), 7'd0);
      chk("idle_ack1", 7'(ack1), 7'd0);
    end

    // 2: source 0 alone, held from reset release
    req0 = 1'b1; src0_d0 = 4'd3; src0_d1 = 4'd1; src0_d2 = 4'd4; src0_dp = 3'b001;
    do_reset();
    while (cyc < 15) step();
    chk("s0_pre_grant", 7'(grant), 7'd0);
    chk("s0_pre_ack0", 7'(ack0), 7'd0);
    step();
    chk("s0_tick_ack0", 7'(ack0), 7'd1);
    chk("s0_tick_ack1", 7'(ack1), 7'd0);
    chk("s0_tick_grant", 7'(grant), 7'b01);
    chk("s0_tick_en", 7'(en), 7'b0001111);
    while (cyc < 46) begin
      step();
      i = ((cyc - 1) / 4) % 3;
      chk("s0_en", 7'(en), 7'(exp_en(i)));
      chk("s0_seg", svn_conf, exp_seg0(i));
      chk("s0_dp", 7'(DP), (i == 0) ? 7'd0 : 7'd1);
      chk("s0_ack0", 7'(ack0), (cyc % 16 == 0) ? 7'd1 : 7'd0);
      chk("s0_grant", 7'(grant), 7'b01);
    end

    // 3: source 1 pulse across the tick at cycle 48
    req1 = 1'b1; src1_d0 = 4'hE; src1_d1 = 4'h0; src1_d2 = 4'h1; src1_dp = 3'b010;
    step();
    chk("p1_between_ack1", 7'(ack1), 7'd0);
    chk("p1_between_grant", 7'(grant), 7'b01);
    step();
    chk("p1_tick_ack1", 7'(ack1), 7'd1);
    chk("p1_tick_ack0", 7'(ack0), 7'd0);
    chk("p1_tick_grant", 7'(grant), 7'b10);
    step();
    chk("p1_ack1_once", 7'(ack1), 7'd0);
    chk("p1_en_d0", 7'(en), 7'b0001110);
    chk("p1_seg_E", svn_conf, 7'b0000110);
    chk("p1_dp_d0", 7'(DP), 7'd1);
    req1 = 1'b0;
    while (cyc < 53) step();
    chk("p1_en_d1", 7'(en), 7'b0001101);
    chk("p1_seg_0", svn_conf, 7'b1000000);
    chk("p1_dp_d1", 7'(DP), 7'd0);
    while (cyc < 64) step();
    chk("hold_ack1", 7'(ack1), 7'd0);
    chk("hold_ack0", 7'(ack0), 7'd0);
    chk("hold_grant", 7'(grant), 7'b10);
    step();
    chk("hold_seg_frozen", svn_conf, 7'b1000000);
    chk("hold_en", 7'(en), 7'b0001101);
    while (cyc < 80) step();
    chk("ret_ack0", 7'(ack0), 7'd1);
    chk("ret_ack1", 7'(ack1), 7'd0);
    chk("ret_grant", 7'(grant), 7'b01);
    step();
    chk("ret_en_d2", 7'(en), 7'b0001011);
    chk("ret_seg_4", svn_conf, 7'b0011001);
    chk("ret_dp_d2", 7'(DP), 7'd1);

    // 4: both sources held
    req1 = 1'b1;
    while (cyc < 120) begin
      step();
      chk("both_ack0", 7'(ack0), 7'd0);
      chk("both_ack1", 7'(ack1), (cyc >= 96 && cyc % 16 == 0) ? 7'd1 : 7'd0);
      chk("both_grant", 7'(grant), (cyc >= 96) ? 7'b10 : 7'b01);
    end

    // 5: one-cycle reset while in HOLD1
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_blank("rst_hold");
    chk("rst_hold_grant", 7'(grant), 7'd0);
    chk("rst_hold_ack0", 7'(ack0), 7'd0);
    chk("rst_hold_ack1", 7'(ack1), 7'd0);
    cyc = 0;
    while (cyc < 15) step();
    chk("post_rst_pre_grant", 7'(grant), 7'd0);
    chk("post_rst_pre_ack1", 7'(ack1), 7'd0);
    step();
    chk("post_rst_tick_ack1", 7'(ack1), 7'd1);
    chk("post_rst_tick_ack0", 7'(ack0), 7'd0);
    chk("post_rst_tick_grant", 7'(grant), 7'b10);
    chk("post_rst_tick_en", 7'(en), 7'b0001111);

`ifdef SEG_DIM_EN
    // 6: dimming duty
    req1 = 1'b0; dim = 1'b1;
    do_reset();
    while (cyc < 16) step();
    while (cyc < 40) begin
      step();
      i = ((cyc - 1) / 4) % 3;
      chk("dim_en", 7'(en), ((cyc - 1) % 4 == 0) ? 7'(exp_en(i)) : 7'b0001111);
      chk("dim_seg", svn_conf, exp_seg0(i));
    end
    dim = 1'b0;
    while (cyc < 52) begin
      step();
      i = ((cyc - 1) / 4) % 3;
      chk("full_en", 7'(en), 7'(exp_en(i)));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
